// File: rtl/vga_pic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pic_pkg
// Purpose  : Shared definitions for the VGA screen scheduler: picture codes,
//            scheduler FSM state encoding and the picture ROM base-offset
//            decode.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pic_pkg;

    typedef logic [2:0] pic_t;

    // Picture codes as seen on pic_num
    localparam pic_t PIC_DEPOSIT = 3'd0;
    localparam pic_t PIC_PLAYING = 3'd1;
    localparam pic_t PIC_GOOD    = 3'd2;
    localparam pic_t PIC_BAD     = 3'd3;
    localparam pic_t PIC_RECORD  = 3'd4;

    // Scheduler FSM state encoding
    localparam logic [1:0] C_ST_DEPOSIT = 2'd0;
    localparam logic [1:0] C_ST_PLAYING = 2'd1;
    localparam logic [1:0] C_ST_RESULT  = 2'd2;

    // ROM base offset of each picture, in units of one picture:
    // deposit 0, playing 1, bad 2, good 3, record 4. The ROM stores the
    // good picture after the bad one, hence the non-monotonic mapping.
    // With a constant pic_size every branch folds to a constant.
    function automatic logic [16:0] pic_base(input pic_t pic, input logic [16:0] pic_size);
        logic [16:0] w_two;
        w_two = pic_size + pic_size;
        case (pic)
            PIC_PLAYING: pic_base = pic_size;
            PIC_BAD:     pic_base = w_two;
            PIC_GOOD:    pic_base = w_two + pic_size;
            PIC_RECORD:  pic_base = w_two + w_two;
            default:     pic_base = 17'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_screen_scheduler_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : result_fifo
// Purpose  : Small synchronous FIFO of 3-bit picture codes holding result
//            events that arrive while a result picture is on screen.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            i_flush          - discard all contents (wins over push/pop)
//            i_push/i_push_data - write one entry
//            i_pop            - remove the head entry
//            o_head           - current head entry (valid when !o_empty)
//            o_count          - number of stored entries
//            o_full/o_empty   - status flags
// Revision : 1.0 - initial release
// ============================================================================
module result_fifo
    import vga_pic_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  pic_t                     i_push_data,
    input  logic                     i_pop,
    output pic_t                     o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int                C_AW   = $clog2(DEPTH);
    localparam logic [C_AW:0]     C_FULL = (C_AW + 1)'(DEPTH);
    localparam logic [C_AW-1:0]   C_ONE  = C_AW'(1);

    pic_t              r_mem [DEPTH];
    logic [C_AW-1:0]   r_wr_ptr;
    logic [C_AW-1:0]   r_rd_ptr;
    logic [C_AW:0]     r_count;
    logic              w_push_ok;
    logic              w_pop_ok;

    assign o_full  = (r_count == C_FULL);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    // A pop in the same cycle frees a slot, so a push into a full FIFO is
    // still accepted when it coincides with a pop.
    assign w_pop_ok  = i_pop && !o_empty && !i_flush;
    assign w_push_ok = i_push && !i_flush && (!o_full || w_pop_ok);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + C_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + C_ONE;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_screen_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : vga_screen_scheduler
// Purpose  : Chooses the full-screen picture shown by the VGA renderer from
//            game event pulses. Result pictures are held for HOLD_CYCLES on
//            screen, further result events are queued, and picture changes
//            are committed only at frame boundaries.
// Ports    : clk, rst                  - clock, synchronous active-high reset
//            ev_start/abort/good/bad/record - one-cycle game event pulses
//            frame_start               - start of vertical blanking pulse
//            pic_num, base_addr        - committed picture and ROM offset
//            hold_busy                 - result hold timer running
//            queue_level               - queued result events
//            drop_cnt                  - lost result events (saturating)
// Revision : 1.0 - initial release
// ============================================================================
module vga_screen_scheduler
    import vga_pic_pkg::*;
#(
    parameter logic [29:0] HOLD_CYCLES = 30'd671088640,
    parameter int          QDEPTH      = 4,
    parameter logic [16:0] PIC_SIZE    = 17'd19200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ev_start,
    input  logic        ev_abort,
    input  logic        ev_good,
    input  logic        ev_bad,
    input  logic        ev_record,
    input  logic        frame_start,
    output logic [2:0]  pic_num,
    output logic [16:0] base_addr,
    output logic        hold_busy,
    output logic [3:0]  queue_level,
    output logic [7:0]  drop_cnt
);

    localparam int C_CW = $clog2(QDEPTH) + 1;

    logic [1:0]       r_state;
    pic_t             r_target;
    pic_t             r_pic;
    logic [16:0]      r_base;
    logic [29:0]      r_timer;
    logic [7:0]       r_drop;

    logic [1:0]       w_state_nxt;
    pic_t             w_target_nxt;
    logic             w_timer_clr;
    logic             w_push;
    logic             w_pop;
    logic             w_flush;
    logic [1:0]       w_drops;
    logic [8:0]       w_drop_sum;

    logic             w_res_valid;
    pic_t             w_res_pic;
    logic [1:0]       w_res_cnt;
    logic [1:0]       w_res_lower;

    logic             w_in_hold;
    logic             w_expire;

    pic_t             w_head;
    logic [C_CW-1:0]  w_count;
    logic             w_full;
    logic             w_empty;

    // ---------------------------------------------------------------------
    // Result event priority: record > good > bad. Pulses below the winner
    // are always lost and feed the drop counter.
    // ---------------------------------------------------------------------
    always_comb begin
        w_res_valid = 1'b1;
        w_res_pic   = PIC_RECORD;
        if (ev_record) begin
            w_res_pic = PIC_RECORD;
        end else if (ev_good) begin
            w_res_pic = PIC_GOOD;
        end else if (ev_bad) begin
            w_res_pic = PIC_BAD;
        end else begin
            w_res_valid = 1'b0;
            w_res_pic   = PIC_DEPOSIT;
        end
    end

    assign w_res_cnt   = {1'b0, ev_record} + {1'b0, ev_good} + {1'b0, ev_bad};
    assign w_res_lower = w_res_cnt - {1'b0, w_res_valid};

    // The timer only runs while the result picture is actually on screen.
    assign w_in_hold = (r_state == C_ST_RESULT) && (r_pic == r_target);
    assign w_expire  = w_in_hold && (r_timer == HOLD_CYCLES - 30'd1);

    // ---------------------------------------------------------------------
    // Scheduler FSM next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        w_timer_clr  = 1'b0;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_flush      = 1'b0;
        w_drops      = 2'd0;
        case (r_state)
            C_ST_DEPOSIT: begin
                if (ev_start) begin
                    w_state_nxt  = C_ST_PLAYING;
                    w_target_nxt = PIC_PLAYING;
                end
            end
            C_ST_PLAYING: begin
                if (ev_abort) begin
                    w_state_nxt  = C_ST_DEPOSIT;
                    w_target_nxt = PIC_DEPOSIT;
                    w_drops      = w_res_cnt;
                end else if (w_res_valid) begin
                    w_state_nxt  = C_ST_RESULT;
                    w_target_nxt = w_res_pic;
                    w_timer_clr  = 1'b1;
                    w_drops      = w_res_lower;
                end
            end
            C_ST_RESULT: begin
                if (ev_abort) begin
                    w_state_nxt  = C_ST_DEPOSIT;
                    w_target_nxt = PIC_DEPOSIT;
                    w_flush      = 1'b1;
                    w_timer_clr  = 1'b1;
                    w_drops      = w_res_cnt;
                end else if (w_expire) begin
                    w_timer_clr = 1'b1;
                    w_drops     = w_res_lower;
                    if (r_target == PIC_RECORD) begin
                        // A record ends the game; pending results are moot.
                        w_state_nxt  = C_ST_DEPOSIT;
                        w_target_nxt = PIC_DEPOSIT;
                        w_flush      = 1'b1;
                    end else if (!w_empty) begin
                        // Old head is shown next; a coincident event goes
                        // into the slot the pop frees.
                        w_pop        = 1'b1;
                        w_push       = w_res_valid;
                        w_target_nxt = w_head;
                    end else if (w_res_valid) begin
                        // Empty queue: the coincident event goes straight
                        // to the screen instead of through the FIFO.
                        w_target_nxt = w_res_pic;
                    end else begin
                        w_state_nxt  = C_ST_PLAYING;
                        w_target_nxt = PIC_PLAYING;
                    end
                end else if (w_res_valid) begin
                    if (w_full) begin
                        w_drops = w_res_lower + 2'd1;
                    end else begin
                        w_push  = 1'b1;
                        w_drops = w_res_lower;
                    end
                end
            end
            default: begin
                w_state_nxt  = C_ST_DEPOSIT;
                w_target_nxt = PIC_DEPOSIT;
                w_flush      = 1'b1;
            end
        endcase
    end

    assign w_drop_sum = {1'b0, r_drop} + {7'd0, w_drops};

    // ---------------------------------------------------------------------
    // State, timer, drop counter and frame-aligned commit
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= C_ST_DEPOSIT;
            r_target <= PIC_DEPOSIT;
            r_pic    <= PIC_DEPOSIT;
            r_base   <= 17'd0;
            r_timer  <= 30'd0;
            r_drop   <= 8'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_target <= w_target_nxt;
            r_drop   <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];

            if (w_timer_clr) begin
                r_timer <= 30'd0;
            end else if (w_in_hold) begin
                r_timer <= r_timer + 30'd1;
            end

            // The registered target is compared, so a target written in the
            // same cycle as frame_start waits for the following frame.
            if (frame_start) begin
                r_pic  <= r_target;
                r_base <= pic_base(r_target, PIC_SIZE);
            end
        end
    end

    result_fifo #(
        .DEPTH (QDEPTH)
    ) u_result_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (w_flush),
        .i_push      (w_push),
        .i_push_data (w_res_pic),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign pic_num     = r_pic;
    assign base_addr   = r_base;
    assign hold_busy   = w_in_hold;
    assign queue_level = 4'(w_count);
    assign drop_cnt    = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_vga_screen_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_screen_scheduler
// Purpose  : Self-checking bench for vga_screen_scheduler. A queue-based
//            reference model tracks the expected screen, hold time, queue
//            and drop count every cycle; directed scenarios add explicit
//            checks on top of that.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_screen_scheduler;

    localparam int C_HOLD   = 16;
    localparam int C_QDEPTH = 4;

    localparam logic [5:0] E_START = 6'd1;
    localparam logic [5:0] E_ABORT = 6'd2;
    localparam logic [5:0] E_BAD   = 6'd4;
    localparam logic [5:0] E_GOOD  = 6'd8;
    localparam logic [5:0] E_REC   = 6'd16;
    localparam logic [5:0] E_RST   = 6'd32;

    logic        clk;
    logic        rst;
    logic        ev_start;
    logic        ev_abort;
    logic        ev_good;
    logic        ev_bad;
    logic        ev_record;
    logic        frame_start;
    logic [2:0]  pic_num;
    logic [16:0] base_addr;
    logic        hold_busy;
    logic [3:0]  queue_level;
    logic [7:0]  drop_cnt;

    int tests;
    int fails;
    int cyc;

    // Reference model: game phase, wanted picture, shown picture, cycles the
    // current result has been visible, lost events and the pending results.
    int m_st;      // 0 deposit, 1 playing, 2 showing results
    int m_tgt;
    int m_pic;
    int m_shown;
    int m_drop;
    int m_q[$];

    vga_screen_scheduler #(
        .HOLD_CYCLES (30'd16),
        .QDEPTH      (C_QDEPTH),
        .PIC_SIZE    (17'd19200)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ev_start    (ev_start),
        .ev_abort    (ev_abort),
        .ev_good     (ev_good),
        .ev_bad      (ev_bad),
        .ev_record   (ev_record),
        .frame_start (frame_start),
        .pic_num     (pic_num),
        .base_addr   (base_addr),
        .hold_busy   (hold_busy),
        .queue_level (queue_level),
        .drop_cnt    (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp_base(input int p);
        case (p)
            1:       return 19200;
            2:       return 57600;
            3:       return 38400;
            4:       return 76800;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    // One clock edge worth of game rules applied to the model.
    task automatic model_step(input bit r, input bit s, input bit a, input bit g,
                              input bit b, input bit rc, input bit fs);
        int  res;
        int  nres;
        int  old_tgt;
        bit  visible;
        bit  done;
        if (r) begin
            m_st = 0; m_tgt = 0; m_pic = 0; m_shown = 0; m_drop = 0;
            m_q.delete();
            return;
        end
        old_tgt = m_tgt;
        visible = (m_st == 2) && (m_pic == m_tgt);
        done    = visible && (m_shown + 1 == C_HOLD);
        res     = rc ? 4 : (g ? 2 : (b ? 3 : -1));
        nres    = int'(rc) + int'(g) + int'(b);
        if (visible && !done) m_shown++;
        if (m_st == 0) begin
            if (s) begin m_st = 1; m_tgt = 1; end
        end else if (m_st == 1) begin
            if (a) begin
                m_st = 0; m_tgt = 0; m_drop += nres;
            end else if (res >= 0) begin
                m_st = 2; m_tgt = res; m_shown = 0; m_drop += nres - 1;
            end
        end else begin
            if (a) begin
                m_st = 0; m_tgt = 0; m_drop += nres; m_q.delete();
            end else if (done) begin
                if (res >= 0) m_drop += nres - 1;
                if (old_tgt == 4) begin
                    m_st = 0; m_tgt = 0; m_q.delete();
                end else begin
                    if (res >= 0) m_q.push_back(res);
                    if (m_q.size() > 0) begin
                        m_tgt = m_q.pop_front(); m_shown = 0;
                    end else begin
                        m_st = 1; m_tgt = 1;
                    end
                end
            end else if (res >= 0) begin
                if (m_q.size() < C_QDEPTH) m_q.push_back(res);
                else m_drop++;
                m_drop += nres - 1;
            end
        end
        if (fs) m_pic = old_tgt;
        if (m_drop > 255) m_drop = 255;
    endtask

    // Drive one cycle of inputs, advance DUT and model, compare all outputs.
    task automatic tick(input logic [5:0] v);
        rst         = v[5];
        ev_start    = v[0];
        ev_abort    = v[1];
        ev_bad      = v[2];
        ev_good     = v[3];
        ev_record   = v[4];
        frame_start = (cyc % 10 == 9);
        @(posedge clk);
        model_step(v[5], v[0], v[1], v[3], v[2], v[4], frame_start);
        #1;
        rst = 1'b0; ev_start = 1'b0; ev_abort = 1'b0;
        ev_bad = 1'b0; ev_good = 1'b0; ev_record = 1'b0;
        cyc++;
        check("pic_num", 32'(pic_num), m_pic);
        check("base_addr", 32'(base_addr), exp_base(m_pic));
        check("hold_busy", 32'(hold_busy), ((m_st == 2) && (m_pic == m_tgt)) ? 1 : 0);
        check("queue_level", 32'(queue_level), m_q.size());
        check("drop_cnt", 32'(drop_cnt), m_drop);
    endtask

    task automatic wait_pic(input int v);
        for (int i = 0; i < 100 && int'(pic_num) != v; i++) tick(6'd0);
        check("wait_pic", 32'(pic_num), v);
    endtask

    initial begin
        int busy_n;
        int seen_good;
        int seq[8];
        int seq_n;
        int last;
        logic [5:0] v;

        tests = 0; fails = 0; cyc = 0;
        m_st = 0; m_tgt = 0; m_pic = 0; m_shown = 0; m_drop = 0;
        rst = 1'b1; ev_start = 1'b0; ev_abort = 1'b0; ev_good = 1'b0;
        ev_bad = 1'b0; ev_record = 1'b0; frame_start = 1'b0;

        // Reset values, then start -> playing picture
        tick(E_RST);
        check("rst_pic", 32'(pic_num), 0);
        check("rst_base", 32'(base_addr), 0);
        check("rst_busy", 32'(hold_busy), 0);
        check("rst_qlvl", 32'(queue_level), 0);
        check("rst_drop", 32'(drop_cnt), 0);
        tick(E_START);
        wait_pic(1);
        check("play_base", 32'(base_addr), 19200);

        // Good ball: shown for exactly the hold time, then back to playing
        tick(E_GOOD);
        busy_n = 0; seen_good = 0;
        for (int i = 0; i < 60; i++) begin
            tick(6'd0);
            if (hold_busy) busy_n++;
            if (pic_num == 3'd2 && base_addr == 17'd57600) seen_good = 1;
        end
        check("good_shown", seen_good, 1);
        check("busy_len", busy_n, C_HOLD);
        check("back_to_play", 32'(pic_num), 1);

        // Five results during a hold: four queued, one dropped
        tick(E_RST);
        tick(E_START);
        wait_pic(1);
        tick(E_GOOD);
        wait_pic(2);
        tick(E_BAD); tick(E_GOOD); tick(E_BAD); tick(E_GOOD); tick(E_BAD);
        check("q_full_lvl", 32'(queue_level), 4);
        check("q_full_drop", 32'(drop_cnt), 1);
        seq_n = 0; last = int'(pic_num);
        for (int i = 0; i < 200; i++) begin
            tick(6'd0);
            if (int'(pic_num) != last) begin
                if (seq_n < 8) seq[seq_n] = int'(pic_num);
                seq_n++;
                last = int'(pic_num);
            end
        end
        check("seq_len", seq_n, 5);
        check("seq0", seq[0], 3);
        check("seq1", seq[1], 2);
        check("seq2", seq[2], 3);
        check("seq3", seq[3], 2);
        check("seq4", seq[4], 1);

        // Abort beats a coincident good ball, which is counted as lost
        tick(E_RST);
        tick(E_START);
        wait_pic(1);
        tick(E_ABORT | E_GOOD);
        for (int i = 0; i < 12; i++) tick(6'd0);
        check("abort_pic", 32'(pic_num), 0);
        check("abort_drop", 32'(drop_cnt), 1);
        check("abort_qlvl", 32'(queue_level), 0);

        // Queued record: shown, then flushes the rest and ends the game
        tick(E_RST);
        tick(E_START);
        wait_pic(1);
        tick(E_GOOD); tick(E_REC); tick(E_BAD);
        wait_pic(4);
        check("rec_base", 32'(base_addr), 76800);
        check("rec_qlvl", 32'(queue_level), 1);
        wait_pic(0);
        check("rec_flush", 32'(queue_level), 0);

        // Reset in the middle of a hold with three queued results
        tick(E_RST);
        tick(E_START);
        wait_pic(1);
        tick(E_GOOD); tick(E_BAD); tick(E_BAD); tick(E_REC);
        check("pre_rst_qlvl", 32'(queue_level), 3);
        tick(E_RST);
        check("mid_rst_pic", 32'(pic_num), 0);
        check("mid_rst_base", 32'(base_addr), 0);
        check("mid_rst_busy", 32'(hold_busy), 0);
        check("mid_rst_qlvl", 32'(queue_level), 0);
        check("mid_rst_drop", 32'(drop_cnt), 0);
        tick(E_GOOD);
        for (int i = 0; i < 15; i++) tick(6'd0);
        check("dep_ignore_pic", 32'(pic_num), 0);
        check("dep_ignore_qlvl", 32'(queue_level), 0);
        tick(E_START);
        wait_pic(1);

        // Random event traffic against the model
        for (int i = 0; i < 2500; i++) begin
            v = 6'd0;
            if ($urandom_range(0, 399) == 0) v = v | E_RST;
            if ($urandom_range(0, 7) == 0)   v = v | E_START;
            if ($urandom_range(0, 59) == 0)  v = v | E_ABORT;
            if ($urandom_range(0, 9) == 0)   v = v | E_GOOD;
            if ($urandom_range(0, 9) == 0)   v = v | E_BAD;
            if ($urandom_range(0, 15) == 0)  v = v | E_REC;
            tick(v);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
